// File: rtl/fir_sched_pkg.sv
// Shared types and defaults for the FIR channel scheduler.
// The FSM encoding is fixed so checkers and waveforms can decode the state directly.
package fir_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } sched_state_t;

    localparam int N_CH_DEFAULT    = 4;
    localparam int DATA_W_DEFAULT  = 8;
    localparam int TIMEOUT_DEFAULT = 128;
    localparam int CH_W_DEFAULT    = $clog2(N_CH_DEFAULT);

endpackage

// File: rtl/fir_channel_scheduler_rr_arbiter.sv
// Combinational round-robin search: the first requester strictly after ptr, wrapping.
module rr_arbiter #(
    parameter  int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [CH_W-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [CH_W-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest hit is the last write.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int i = N_CH; i >= 1; i--) begin
            idx = CH_W'((int'(ptr) + i) % N_CH);
            if (req[idx]) begin
                gnt_idx = idx;
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Shares one FIR MAC engine across N_CH sample channels: one-deep buffer per channel,
// round-robin issue, start/done handshake with a watchdog, valid/ready result port.
module fir_channel_scheduler
    import fir_sched_pkg::*;
#(
    parameter  int N_CH    = N_CH_DEFAULT,
    parameter  int DATA_W  = DATA_W_DEFAULT,
    parameter  int TIMEOUT = TIMEOUT_DEFAULT,
    localparam int CH_W    = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic [N_CH*DATA_W-1:0] in_data,
    output logic                   eng_start,
    output logic [CH_W-1:0]        eng_ch,
    output logic [DATA_W-1:0]      eng_sample,
    input  logic                   eng_done,
    input  logic [DATA_W-1:0]      eng_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH_W-1:0]        out_ch,
    output logic [DATA_W-1:0]      out_data,
    output logic                   err_timeout,
    output logic                   busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and a raised out_valid holds its payload until taken.

    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    sched_state_t      state, state_nxt;
    logic [N_CH-1:0]   pend;
    logic [N_CH-1:0]   pend_set, pend_clr;
    logic [DATA_W-1:0] sample_buf [N_CH];
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant;
    logic [WD_W-1:0]   wdog;
    logic              wd_last;
    logic [CH_W-1:0]   arb_idx;
    logic              arb_any;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req     (pend),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign in_ready = ~pend;
    assign eng_ch   = grant;
    assign wd_last  = (wdog == WD_LAST);
    assign pend_set = in_valid & ~pend;
    assign pend_clr = (state == ISSUE) ? (N_CH'(1) << grant) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_any) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                // A done on the watchdog's final cycle still counts as a good result.
                if (eng_done)     state_nxt = OUT;
                else if (wd_last) state_nxt = IDLE;
            end
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        eng_start   = (state == ISSUE);
        err_timeout = (state == WAIT) && !eng_done && wd_last;
        busy        = (state != IDLE);
    end

    // Channel buffers: a slot accepts only while empty and frees as its job leaves ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            for (int c = 0; c < N_CH; c++) sample_buf[c] <= '0;
        end else begin
            pend <= (pend | pend_set) & ~pend_clr;
            for (int c = 0; c < N_CH; c++) begin
                if (pend_set[c]) sample_buf[c] <= in_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // Grant and engine operands are frozen at the IDLE decision and held through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= CH_W'(N_CH - 1);
            grant      <= '0;
            eng_sample <= '0;
        end else if (state == IDLE && arb_any) begin
            rr_ptr     <= arb_idx;
            grant      <= arb_idx;
            eng_sample <= sample_buf[arb_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog <= '0;
        end else if (state == ISSUE) begin
            wdog <= '0;
        end else if (state == WAIT && !eng_done) begin
            wdog <= wdog + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else if (state == WAIT && eng_done) begin
            out_valid <= 1'b1;
            out_ch    <= grant;
            out_data  <= eng_result;
        end else if (state == OUT && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
